// File: rtl/uop_buffer.sv
// Circular uop buffer: in-order fill/free, random-access read. Write visible the cycle after acceptance;
// wr_ready is !full from registered state only, so a full buffer stalls the writer even while popping.
module uop_buffer #(
    parameter int UOP_BUF_SIZE = 16,
    parameter int BUNDLE_W = 32,
    localparam int AW = $clog2(UOP_BUF_SIZE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [BUNDLE_W-1:0] wr_bundle,
    input  logic [AW-1:0]       uop_addr,
    output logic [BUNDLE_W-1:0] uop,
    output logic                uop_valid,
    input  logic                consume,
    output logic [AW-1:0]       head,
    output logic [AW:0]         count,
    output logic                empty,
    output logic                full
);

    logic [BUNDLE_W-1:0] mem [UOP_BUF_SIZE];
    logic [AW-1:0]       tail;
    logic [AW-1:0]       offset;
    logic                write_fire;
    logic                pop_fire;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(UOP_BUF_SIZE));
    assign wr_ready   = !full;
    assign write_fire = wr_valid && wr_ready && !clear;
    assign pop_fire   = consume && !empty && !clear;

    // Distance from head wraps naturally in AW bits; valid if inside the occupied window.
    assign offset    = uop_addr - head;
    assign uop_valid = ({1'b0, offset} < count);
    assign uop       = mem[uop_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < UOP_BUF_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else if (write_fire) begin
            mem[tail] <= wr_bundle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (write_fire) begin
                tail <= tail + 1'b1;
            end
            if (pop_fire) begin
                head <= head + 1'b1;
            end
            case ({write_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/uop_buffer.md
# uop_buffer

Circular buffer of `instruction_bundle` entries between the macro-instruction expander (writer) and `uop_fetch` (reader) in the microcode unit. It accepts one bundle per cycle through a valid/ready handshake. It serves random-access reads at the fetch-supplied `uop_addr` and frees entries in order when fetch signals consumption. A pipeline flush empties it in one cycle.

## Interface
- `UOP_BUF_SIZE`, default 16: number of entries; must be a power of two, ≥ 2.
- `AW`, default `$clog2(UOP_BUF_SIZE)`: address width (derived, not overridden).

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `clear`  in  1: synchronous flush (driven by `flush_pipeline`).
- `wr_valid`  in  1: writer offers `wr_bundle`.
- `wr_ready`  out  1: buffer can accept a write this cycle.
- `wr_bundle`  in  `instruction_bundle`: bundle to append at tail.
- `uop_addr`  in  AW: read address from `uop_fetch`.
- `uop`  out  `instruction_bundle`: entry contents at `uop_addr`, read combinationally.
- `uop_valid`  out  1: entry at `uop_addr` is currently occupied.
- `consume`  in  1: fetch has taken the head bundle; pop it.
- `head`  out  AW: index of the oldest occupied entry.
- `count`  out  AW+1: number of occupied entries, 0..UOP_BUF_SIZE.
- `empty`  out  1: `count == 0`.
- `full`  out  1: `count == UOP_BUF_SIZE`.

## Operation
- **State:** entry array `mem[UOP_BUF_SIZE]`, `head` (AW bits), `tail` (AW bits), `count` (AW+1 bits).
- **Write fire:** `wr_valid && wr_ready && !clear`. Stores `wr_bundle` into `mem[tail]` and sets `tail <= tail+1`. `tail` wraps modulo UOP_BUF_SIZE through natural AW-bit overflow.
- **`wr_ready`:** equals `!full`. It is combinational from registered state and never depends on `consume` in the same cycle.
- **Pop fire:** `consume && !empty && !clear`. Sets `head <= head+1` with the same wrap rule. When the buffer is empty, `consume` is ignored; this is not an error.
- **Count update:** `count <= count + write_fire − pop_fire`. A simultaneous write and pop leaves `count` unchanged and moves both pointers.
- **`uop_valid`:** `((uop_addr − head) mod UOP_BUF_SIZE) < count`, using AW-bit unsigned subtraction zero-extended to AW+1 bits. When full, every address is valid. When empty, none is.
- **`uop` read:** always returns `mem[uop_addr]`, even when `uop_valid` is 0 (stale data). Consumers must qualify it with `uop_valid`.
- **Clear:** sets `head`, `tail` and `count` to 0. Clear has priority over a write or pop in the same cycle; both are dropped. `mem` contents are not erased.
- **Reset:** asynchronously sets `head`, `tail` and `count` to 0 and zeroes all `mem` entries. Reset asserted mid-operation discards all content immediately, with no wait for a clock edge.

## Timing
- **Reset values:** `head=0`, `count=0`, `empty=1`, `full=0`, `wr_ready=1`, `uop_valid=0`, `uop=0`.
- **Write latency:** a bundle written at edge N appears on `uop` (when addressed) with `uop_valid=1` after edge N, i.e. it is usable in cycle N+1. There is no write-to-read bypass within the same cycle.
- **Pop latency:** after a pop at edge N, `head`, `count` and `uop_valid` reflect the freed entry in cycle N+1.
- **Combinational paths:**
  - `uop_addr` → `uop` and `uop_valid`.
  - No combinational path from `wr_valid` or `consume` to any output.
- **Boundary behaviour:**
  - When full, `wr_ready=0`, including when `consume=1` in the same cycle. Throughput when full is therefore one bubble, which is accepted.
  - Wrap-around: pointers roll from UOP_BUF_SIZE−1 to 0 without disturbing `count`.
  - After `clear`, `wr_ready` returns to 1 the following cycle.

## Test plan
- **Reset then idle:** assert `reset` asynchronously between edges → outputs immediately `count=0`, `empty=1`, `wr_ready=1`, `uop_valid=0` at `uop_addr=0`.
- **Fill to full:** write 16 bundles tagged 0x100..0x10F on consecutive cycles → `count=16`, `full=1`, `wr_ready=0`; reading `uop_addr=5` gives 0x105 with `uop_valid=1`. A 17th `wr_valid` is not accepted.
- **Wrap-around:** fill 16, consume 4 (`head=4`), then write 0x200..0x203 → entries 0..3 hold 0x200..0x203, `count=16`. `uop_addr=3` → 0x203 valid; `uop_addr=4` → 0x104 valid.
- **Simultaneous write and consume with `count=8`:** → `count` stays 8, `head` and `tail` each advance by 1. With the buffer full and both asserted → only the pop fires and `count=15`.
- **Consume on empty and `uop_valid` window:** consume at `count=0` → `head` unchanged. After 3 writes with `head=0`: `uop_addr=2` is valid, `uop_addr=3` is invalid.
- **Clear priority:** with `count=10`, assert `clear`, `wr_valid` and `consume` together → next cycle `count=0`, `head=0`, `empty=1`, `uop_valid=0` at every address.
